popcnt_serial_hs: RTL and testbench
===================================

Name: popcnt_serial_hs

Overview:
- Multi-cycle population counter: accepts a WIDTH-bit word over a valid/ready handshake and counts its ones (or zeros) at LANES bits per clock.
- Returns the count over a second valid/ready handshake.
- Parametrised successor to the team's fixed 16-bit, 1-bit-per-cycle ones counter; adds a handshake, zero-count mode and a throughput/area trade-off.
- Sits between a producer (status/mask registers, packet bitmaps) and a consumer that needs a set-bit count.

Parameters:
- WIDTH, 16, input word width; must be ≥1 and a multiple of LANES.
- LANES, 4, bits consumed per COUNT cycle; 1 ≤ LANES ≤ WIDTH.
- STEPS, WIDTH/LANES, derived localparam; number of COUNT cycles.
- CNT_W, $clog2(WIDTH+1), derived localparam; result width (0..WIDTH).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block can accept a word (IDLE only).
- in_data  input  WIDTH  word to count.
- in_count_zeros  input  1  1 = count zeros, 0 = count ones; sampled with in_data.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- out_count  output  CNT_W  result.
- busy  output  1  high in COUNT or DONE.

Behaviour:
- Reset is asynchronous and active-high; clock is clk. Reset forces:
  - state = IDLE, in_ready = 1, out_valid = 0, busy = 0, out_count = 0;
  - shift register = 0, step index = 0, accumulator = 0.
- FSM states: IDLE, COUNT, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready at edge T: shreg ← in_count_zeros ? ~in_data : in_data; acc ← 0; idx ← 0; go to COUNT.
- COUNT:
  - Each cycle: acc ← acc + popcount(shreg[LANES-1:0]); shreg ← shreg >> LANES; idx ← idx + 1.
  - When idx == STEPS-1, the final add occurs and the state goes to DONE.
- DONE:
  - out_valid = 1 and out_count = acc, stable until the handshake completes.
  - On out_ready, go to IDLE at the next edge.
  - out_count keeps its last value after leaving DONE; consumers must not rely on it then.
- Latency: out_valid is asserted exactly STEPS cycles after the accepting edge T.
  - Minimum throughput is one word per STEPS+2 cycles (accept, STEPS counts, one DONE cycle).
- No overlap: in_ready = 0 in COUNT and DONE; in_valid is ignored there.
- Width rules:
  - acc is CNT_W bits and cannot overflow (maximum WIDTH).
  - Per-step popcount is $clog2(LANES+1) bits, zero-extended before the add.
- Boundaries:
  - All-ones word gives WIDTH; all-zeros gives 0; with in_count_zeros the results are inverted accordingly.
  - LANES == WIDTH: STEPS = 1, single COUNT cycle.
  - out_ready held high before DONE is legal; the handshake then completes in the first DONE cycle.
  - Reset asserted in any state aborts immediately; the partial result is discarded.
- busy = (state != IDLE).

Optional Feature:
- Macro: POPCNT_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit), sampled synchronously.
  - abort = 1 in COUNT or DONE returns the FSM to IDLE at the next edge, clears acc to 0 and drops out_valid; no result is produced.
  - abort in IDLE has no effect and has priority over in_valid in that cycle (no accept).
- Not defined: the port is absent and the FSM runs as above.

Decomposition:
- Package popcnt_pkg:
  - state enum (IDLE, COUNT, DONE), 2-bit encoding;
  - function cnt_width(w) = $clog2(w+1).
- Sub-module popcnt_lane:
  - purely combinational popcount of a LANES-bit slice;
  - parameter LANES, output $clog2(LANES+1) bits.
- Top holds the FSM, shift register, index counter and accumulator.

Test Plan:
- WIDTH=16, LANES=4; in_data=16'hFFFF, zeros=0 → out_valid 4 cycles after accept, out_count=16.
- in_data=16'hA5C3, zeros=0 → out_count=8; same word with zeros=1 → out_count=8; 16'h0000 with zeros=1 → 16.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_count and out_valid stable, in_ready=0, a new in_valid is not accepted. Raise out_ready → IDLE next cycle, then accept the next word.
- Reset asserted during the 2nd COUNT cycle → outputs return immediately to reset values. Next word 16'h000F → out_count=4.
- WIDTH=16, LANES=1, in_data=16'h8001 → out_valid 16 cycles after accept, out_count=2. LANES=16 → latency 1, out_count=2.
- With POPCNT_ABORT_EN: abort in the 3rd COUNT cycle → IDLE next edge, out_valid never asserted. Random 1000-word soak against a reference popcount yields zero mismatches.

Source files
------------

// File: rtl/popcnt_pkg.sv
// Shared types and helpers for the serial population counter.
package popcnt_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StCount = 2'd1,
        StDone  = 2'd2
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/popcnt_lane.sv
// Combinational popcount of one LANES-bit slice.
module popcnt_lane
    import popcnt_pkg::*;
#(
    parameter  int unsigned LANES = 4,
    localparam int unsigned OUT_W = cnt_width(LANES)
) (
    input  logic [LANES-1:0] bits,
    output logic [OUT_W-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < LANES; i++) begin
            count = count + OUT_W'(bits[i]);
        end
    end

endmodule

// File: rtl/popcnt_serial_hs.sv
// Multi-cycle ones/zeros counter with valid/ready handshakes on both sides.
// Define POPCNT_ABORT_EN to add a synchronous abort input.
module popcnt_serial_hs
    import popcnt_pkg::*;
#(
    parameter  int unsigned WIDTH = 16,
    parameter  int unsigned LANES = 4,
    localparam int unsigned CNT_W = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_count_zeros,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             busy
`ifdef POPCNT_ABORT_EN
    ,
    input  logic             abort
`endif
);

    localparam int unsigned STEPS  = WIDTH / LANES;
    localparam int unsigned LANE_W = cnt_width(LANES);
    localparam int unsigned IDX_W  = (STEPS > 1) ? $clog2(STEPS) : 1;

    if (LANES < 1 || LANES > WIDTH || (WIDTH % LANES) != 0) begin : g_param_check
        $error("popcnt_serial_hs: WIDTH must be a non-zero multiple of LANES");
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   acc_q, acc_d;
    logic [LANE_W-1:0]  lane_cnt;
    logic               abort_req;

`ifdef POPCNT_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    popcnt_lane #(
        .LANES (LANES)
    ) u_lane (
        .bits  (shreg_q[LANES-1:0]),
        .count (lane_cnt)
    );

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        idx_d     = idx_q;
        acc_d     = acc_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Abort outranks a new word, so ready is withheld while it is high.
                in_ready = !abort_req;
                if (in_valid && !abort_req) begin
                    shreg_d = in_count_zeros ? ~in_data : in_data;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = StCount;
                end
            end
            StCount: begin
                if (abort_req) begin
                    acc_d   = '0;
                    state_d = StIdle;
                end else begin
                    acc_d   = acc_q + CNT_W'(lane_cnt);
                    shreg_d = shreg_q >> LANES;
                    idx_d   = idx_q + IDX_W'(1);
                    if (idx_q == IDX_W'(STEPS - 1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                out_valid = !abort_req;
                if (abort_req) begin
                    acc_d   = '0;
                    state_d = StIdle;
                end else if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            shreg_q <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
        end
    end

    // The accumulator doubles as the result register; it holds after DONE.
    assign out_count = acc_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_popcnt_serial_hs.sv
// Randomised self-checking bench for popcnt_serial_hs (LANES = 4, 1 and 16 variants).
module tb_popcnt_serial_hs;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_count_zeros = 1'b0;
    logic        out_ready = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] in_data = '0;

    logic       in_ready, out_valid, busy;
    logic [4:0] out_count;
    logic       rdy1, ov1, bsy1;
    logic [4:0] cnt1;
    logic       rdy16, ov16, bsy16;
    logic [4:0] cnt16;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    popcnt_serial_hs #(.WIDTH(16), .LANES(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_count_zeros(in_count_zeros), .out_valid(out_valid),
        .out_ready(out_ready), .out_count(out_count), .busy(busy)
`ifdef POPCNT_ABORT_EN
        , .abort(abort)
`endif
    );

    popcnt_serial_hs #(.WIDTH(16), .LANES(1)) dut_l1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1),
        .in_data(in_data), .in_count_zeros(in_count_zeros), .out_valid(ov1),
        .out_ready(out_ready), .out_count(cnt1), .busy(bsy1)
`ifdef POPCNT_ABORT_EN
        , .abort(abort)
`endif
    );

    popcnt_serial_hs #(.WIDTH(16), .LANES(16)) dut_l16 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy16),
        .in_data(in_data), .in_count_zeros(in_count_zeros), .out_valid(ov16),
        .out_ready(out_ready), .out_count(cnt16), .busy(bsy16)
`ifdef POPCNT_ABORT_EN
        , .abort(abort)
`endif
    );

    // Reference: number of selected-polarity bits in a 16-bit word.
    function automatic int ref_count(input logic [15:0] d, input logic z);
        return z ? 16 - $countones(d) : $countones(d);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; abort = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Offer one word, measure cycles from the accepting edge to out_valid, then drain.
    task automatic run_word(input logic [15:0] d, input logic z, input int stall,
                            output int lat, output logic [4:0] c);
        int guard;
        @(negedge clk);
        in_data = d; in_count_zeros = z; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        n_cmp++;
        if (guard >= 50) begin
            n_err++;
            $display("FAIL accept_timeout: in_ready=%b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data = 16'($urandom);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        repeat (stall) @(posedge clk);
        #1;
        c = out_count;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_count !== 5'd0) begin
            n_err++;
            $display("FAIL reset_values: rdy=%b ov=%b busy=%b cnt=%0d required 1 0 0 0",
                     in_ready, out_valid, busy, out_count);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [15:0] words [4] = '{16'hFFFF, 16'hA5C3, 16'hA5C3, 16'h0000};
        logic        zs    [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        int          lat;
        logic [4:0]  c;
        for (int i = 0; i < 4; i++) begin
            run_word(words[i], zs[i], 0, lat, c);
            n_cmp++;
            if (lat != 4 || int'(c) != ref_count(words[i], zs[i])) begin
                n_err++;
                $display("FAIL basic_%0d: lat=%0d cnt=%0d required lat=4 cnt=%0d",
                         i, lat, c, ref_count(words[i], zs[i]));
            end
            n_cmp++;
            if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL basic_idle_%0d: rdy=%b busy=%b ov=%b required 1 0 0",
                         i, in_ready, busy, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int exp0;
        @(negedge clk);
        in_data = 16'h1234; in_count_zeros = 1'b0; in_valid = 1'b1;
        exp0 = ref_count(16'h1234, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        @(negedge clk);
        in_data = 16'hFFFF; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || int'(out_count) != exp0 || in_ready !== 1'b0 ||
                busy !== 1'b1) begin
                n_err++;
                $display("FAIL bp_hold_%0d: ov=%b cnt=%0d rdy=%b busy=%b required 1 %0d 0 1",
                         k, out_valid, out_count, in_ready, busy, exp0);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL bp_release: rdy=%b ov=%b busy=%b required 1 0 0",
                     in_ready, out_valid, busy);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL bp_next_accept: busy=%b required 1", busy);
        end
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++;
        if (lat != 4 || int'(out_count) != ref_count(16'hFFFF, 1'b0)) begin
            n_err++;
            $display("FAIL bp_next_word: lat=%0d cnt=%0d required lat=4 cnt=16", lat, out_count);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int         lat;
        logic [4:0] c;
        @(negedge clk);
        in_data = 16'hFFFF; in_count_zeros = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_count !== 5'd0) begin
            n_err++;
            $display("FAIL reset_mid: rdy=%b ov=%b busy=%b cnt=%0d required 1 0 0 0",
                     in_ready, out_valid, busy, out_count);
        end
        @(negedge clk);
        reset = 1'b0;
        run_word(16'h000F, 1'b0, 0, lat, c);
        n_cmp++;
        if (lat != 4 || int'(c) != ref_count(16'h000F, 1'b0)) begin
            n_err++;
            $display("FAIL after_reset_word: lat=%0d cnt=%0d required lat=4 cnt=4", lat, c);
        end
    endtask

    task automatic test_lanes();
        int l4 = -1, l1 = -1, l16 = -1;
        do_reset();
        @(negedge clk);
        in_data = 16'h8001; in_count_zeros = 1'b0; in_valid = 1'b1;
        n_cmp++;
        if (!(in_ready && rdy1 && rdy16)) begin
            n_err++;
            $display("FAIL lanes_ready: rdy=%b%b%b required 111", in_ready, rdy1, rdy16);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clk); #1;
            if (out_valid && l4 < 0)  l4 = k;
            if (ov1 && l1 < 0)        l1 = k;
            if (ov16 && l16 < 0)      l16 = k;
        end
        n_cmp++;
        if (l1 != 16 || int'(cnt1) != ref_count(16'h8001, 1'b0)) begin
            n_err++;
            $display("FAIL lanes1: lat=%0d cnt=%0d required lat=16 cnt=2", l1, cnt1);
        end
        n_cmp++;
        if (l16 != 1 || int'(cnt16) != ref_count(16'h8001, 1'b0)) begin
            n_err++;
            $display("FAIL lanes16: lat=%0d cnt=%0d required lat=1 cnt=2", l16, cnt16);
        end
        n_cmp++;
        if (l4 != 4 || int'(out_count) != ref_count(16'h8001, 1'b0)) begin
            n_err++;
            $display("FAIL lanes4: lat=%0d cnt=%0d required lat=4 cnt=2", l4, out_count);
        end
        do_reset();
    endtask

`ifdef POPCNT_ABORT_EN
    task automatic test_abort();
        int seen = 0;
        @(negedge clk);
        in_data = 16'hFFFF; in_count_zeros = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_count !== 5'd0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL abort_count: busy=%b ov=%b cnt=%0d rdy=%b required 0 0 0 1",
                     busy, out_valid, out_count, in_ready);
        end
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++;
            $display("FAIL abort_no_result: out_valid cycles=%0d required 0", seen);
        end
        @(negedge clk);
        abort = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL abort_idle_priority: busy=%b required 0", busy);
        end
    endtask
`endif

    task automatic test_soak();
        int          lat;
        logic [4:0]  c;
        logic [15:0] d;
        logic        z;
        for (int i = 0; i < 1000; i++) begin
            d = 16'($urandom);
            if ((i % 10) == 0) d = 16'hFFFF;
            if ((i % 10) == 1) d = 16'h0000;
            z = 1'($urandom);
            run_word(d, z, int'($urandom_range(0, 2)), lat, c);
            n_cmp++;
            if (lat != 4 || int'(c) != ref_count(d, z)) begin
                n_err++;
                $display("FAIL soak_%0d: data=%h zeros=%b lat=%0d cnt=%0d required lat=4 cnt=%0d",
                         i, d, z, lat, c, ref_count(d, z));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_mid();
        test_lanes();
`ifdef POPCNT_ABORT_EN
        test_abort();
`endif
        test_soak();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
